seg_scan4: RTL
==============

SEG_SCAN4 -- requirements
Module: seg_scan4

Interface
REQ-001 Parameter SCAN_DIV, default 1000: cck cycles each digit stays lit; legal range 2..65535.
REQ-002 Port cck  in  1  sole clock; all state updates on rising edge.
REQ-003 Port cclr  in  1  asynchronous active-low reset.
REQ-004 Port datain  in  4  low nibble from the upstream counter's dataout; synchronous to cck.
REQ-005 Port rco  in  1  upstream ripple-carry, active-high, synchronous to cck.
REQ-006 Port updown  in  1  count direction of the upstream counter; 1 = up, 0 = down.
REQ-007 Port rck  in  1  display-capture strobe, synchronous to cck.
REQ-008 Port ovfclr  in  1  synchronous clear of the overflow flag, active-high.
REQ-009 Port g  in  1  output enable, active-low.
REQ-010 Port seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 Port an  out  4  digit anodes, one-hot active-low, registered.
REQ-012 Port dp  out  1  decimal point, active-low, registered.
REQ-013 Port ovf  out  1  sticky overflow/underflow flag, registered.

Function
REQ-014 Cascade: keep upper BCD digits d3..d1 (12 bits); d0 is always the live datain.
REQ-015 rco edge = rco high now and low on the previous cck edge; level-high rco counts once.
REQ-016 On rco edge with updown=1, d3..d1 increments in BCD; 999 wraps to 000 and sets ovf.
REQ-017 On rco edge with updown=0, d3..d1 decrements in BCD; 000 wraps to 999 and sets ovf.
REQ-018 rck edge (same rule as REQ-015) loads disp[15:0] = {d3,d2,d1,datain} on that same cck edge.
REQ-019 rck edge coincident with rco edge: disp captures the pre-update d3..d1 value.
REQ-020 ovfclr=1 clears ovf next edge; a coincident wrap event wins and keeps ovf set.
REQ-021 Prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and digit index idx advances 0,1,2,3,0.
REQ-022 an drives a 0 only on bit idx; seg shows the hex decode of disp nibble idx (values A-F shown as hex glyphs).
REQ-023 dp is 0 only when idx=3 and ovf=1.
REQ-024 seg, an and dp are registered one cck after idx/disp change (latency 1).
REQ-025 g=1 forces seg=7'h7F, an=4'hF, dp=1 on the next edge; scanning and cascade continue internally.

Reset
REQ-026 cclr=0 immediately forces d3..d1=0, disp=0, idx=0, prescaler=0, ovf=0, edge-history regs=0.
REQ-027 cclr=0 forces outputs seg=7'h7F, an=4'hF, dp=1.
REQ-028 First cck edge after cclr release drives an=4'hE with the digit-0 glyph.
REQ-029 Reset asserted mid-scan or mid-wrap discards all state; no partial update survives.

Configuration
REQ-030 Macro SEG_SCAN4_BLANK_EN: when defined, leading zero digits among disp[15:4] are blanked.
REQ-031 Blanking: seg=7'h7F and the anode stays active; d0 is never blanked.
REQ-032 Without SEG_SCAN4_BLANK_EN, all four digits always display their glyph.

Structure
REQ-033 Package seg_pkg holds the 16 hex glyph constants, the blank code 7'h7F and the BCD digit type.
REQ-034 One sub-module, seg_dec: combinational nibble-to-7-segment decoder; seg_scan4 instantiates it once, on the muxed nibble.

Verification
REQ-035 Bench: cclr pulse -> seg=7F, an=F, ovf=0; first edge after release an=E, seg=glyph of datain.
REQ-036 Bench: updown=1, 12 rco pulses, datain=5, rck pulse -> disp=0x0125; digits scan E,D,B,7 every SCAN_DIV cycles.
REQ-037 Bench: preload 999 via 999 rco pulses, one more rco -> d3..d1=000, ovf=1, dp=0 on digit 3; ovfclr -> ovf=0.
REQ-038 Bench: updown=0 from 000, one rco -> 999, ovf=1; rco held high 10 cycles -> exactly one decrement.
REQ-039 Bench: rck and rco edges on the same cycle at upper=041 -> disp upper=041, then d3..d1=042.
REQ-040 Bench: g=1 -> an=F, seg=7F next edge; with SEG_SCAN4_BLANK_EN, disp=0x0007 -> digits 3..1 blank, digit 0 shows 7.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit multiplexed display: hex glyphs,
// the BCD digit type and the three-digit BCD up/down step helper.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t d3;
        bcd_t d2;
        bcd_t d1;
    } upper_t;

    typedef struct packed {
        upper_t val;
        logic   wrap;
    } bcd_step_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_0   = 7'h40;
    localparam logic [6:0] GLYPH_1   = 7'h79;
    localparam logic [6:0] GLYPH_2   = 7'h24;
    localparam logic [6:0] GLYPH_3   = 7'h30;
    localparam logic [6:0] GLYPH_4   = 7'h19;
    localparam logic [6:0] GLYPH_5   = 7'h12;
    localparam logic [6:0] GLYPH_6   = 7'h02;
    localparam logic [6:0] GLYPH_7   = 7'h78;
    localparam logic [6:0] GLYPH_8   = 7'h00;
    localparam logic [6:0] GLYPH_9   = 7'h10;
    localparam logic [6:0] GLYPH_A   = 7'h08;
    localparam logic [6:0] GLYPH_B   = 7'h03;
    localparam logic [6:0] GLYPH_C   = 7'h46;
    localparam logic [6:0] GLYPH_D   = 7'h21;
    localparam logic [6:0] GLYPH_E   = 7'h06;
    localparam logic [6:0] GLYPH_F   = 7'h0E;

    // Ripple a BCD +/-1 through d1..d3; wrap is the carry/borrow out of d3.
    function automatic bcd_step_t bcd_step(input upper_t u, input logic up);
        bcd_step_t   r;
        logic [11:0] v;
        bcd_t        nib;
        logic        carry;
        v     = u;
        carry = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (carry) begin
                nib = v[i*4 +: 4];
                if (up) begin
                    if (nib >= 4'd9) nib = 4'd0;
                    else begin
                        nib   = nib + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) nib = 4'd9;
                    else begin
                        nib   = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
                v[i*4 +: 4] = nib;
            end
        end
        r.val  = v;
        r.wrap = carry;
        return r;
    endfunction

endpackage

// File: rtl/seg_dec.sv
// Combinational nibble to active-low 7-segment decoder, hex glyphs 0-F.
module seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan4.sv
// Cascaded BCD extender (d3..d1) plus 4-digit multiplexed display driver.
// Optional leading-zero blanking: define SEG_SCAN4_BLANK_EN.
module seg_scan4
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       cck,
    input  logic       cclr,
    input  logic [3:0] datain,
    input  logic       rco,
    input  logic       updown,
    input  logic       rck,
    input  logic       ovfclr,
    input  logic       g,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       ovf
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    upper_t      upper;
    logic [15:0] disp;
    logic [15:0] presc;
    logic [1:0]  idx;
    logic        rco_q;
    logic        rck_q;

    logic        rco_edge;
    logic        rck_edge;
    bcd_step_t   step;
    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic        blank;
    logic [3:0]  an_next;

    assign rco_edge = rco & ~rco_q;
    assign rck_edge = rck & ~rck_q;
    assign step     = bcd_step(upper, updown);
    assign nib      = disp[{idx, 2'b00} +: 4];
    assign an_next  = ~(4'b0001 << idx);

    seg_dec u_dec (
        .nib (nib),
        .seg (glyph)
    );

`ifdef SEG_SCAN4_BLANK_EN
    logic z3, z2, z1;
    // A digit is a leading zero only if every digit above it is also zero.
    assign z3 = (disp[15:12] == 4'd0);
    assign z2 = z3 && (disp[11:8] == 4'd0);
    assign z1 = z2 && (disp[7:4] == 4'd0);

    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd3:    blank = z3;
            2'd2:    blank = z2;
            2'd1:    blank = z1;
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Cascade, capture and overflow; disp takes the pre-update upper digits.
    always_ff @(posedge cck or negedge cclr) begin
        if (!cclr) begin
            upper <= '0;
            disp  <= '0;
            ovf   <= 1'b0;
            rco_q <= 1'b0;
            rck_q <= 1'b0;
        end else begin
            rco_q <= rco;
            rck_q <= rck;
            if (rck_edge)
                disp <= {upper, datain};
            if (rco_edge)
                upper <= step.val;
            if (rco_edge && step.wrap)
                ovf <= 1'b1;
            else if (ovfclr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge cck or negedge cclr) begin
        if (!cclr) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    always_ff @(posedge cck or negedge cclr) begin
        if (!cclr) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else if (g) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= blank ? SEG_BLANK : glyph;
            an  <= an_next;
            dp  <= ~((idx == 2'd3) && ovf);
        end
    end

endmodule
